apmu_ibex_multdiv_iter: RTL and testbench

- Parametrised iterative RV32M multiply/divide engine. Operand width, bits retired per cycle and constant-time mode are all configurable. Exchanges operands and results through valid/ready handshakes.
- Successor to the fixed-width slow multdiv path: owns its own partial-result registers, so it no longer borrows the EX-stage ALU adder or the shared intermediate-value register.
- Sits in the EX block beside the ALU. The EX result mux selects it when mult_sel/div_sel is set.

---
 rtl/apmu_ibex_pkg.sv | 19 +
 rtl/apmu_ibex_md_step.sv | 46 ++++
 rtl/apmu_ibex_multdiv_iter.sv | 191 +++++++++++++++++++
 tb/tb_apmu_ibex_multdiv_iter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apmu_ibex_pkg.sv
// Shared types for the EX-stage multiply/divide engine.
// Operator encoding and iterative-engine state encoding.
package apmu_ibex_pkg;

  typedef enum logic [1:0] {
    MD_OP_MULL = 2'd0,
    MD_OP_MULH = 2'd1,
    MD_OP_DIV  = 2'd2,
    MD_OP_REM  = 2'd3
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } md_iter_state_e;

endpackage

// File: rtl/apmu_ibex_md_step.sv
// One combinational iteration: BITS_PER_CYCLE multiply-accumulate steps (MSB-first
// Horner form) or BITS_PER_CYCLE restoring-divide steps.
module apmu_ibex_md_step #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   opnd_i,
  input  logic [WIDTH-1:0]   shreg_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0]   shreg_o
);

  localparam int BPC = BITS_PER_CYCLE;

  logic [WIDTH:0]       rem;
  logic [WIDTH:0]       diff;
  logic [WIDTH-1:0]     sh;
  logic [WIDTH+BPC-1:0] pp;

  always_comb begin
    acc_o   = acc_i;
    shreg_o = shreg_i;
    rem     = acc_i[WIDTH:0];
    sh      = shreg_i;
    diff    = '0;
    pp      = '0;
    if (div_i) begin
      // Dividend bits leave at the top of sh while quotient bits enter at the bottom.
      for (int i = 0; i < BPC; i++) begin
        rem  = {rem[WIDTH-1:0], sh[WIDTH-1]};
        diff = rem - {1'b0, opnd_i};
        sh   = {sh[WIDTH-2:0], ~diff[WIDTH]};
        if (!diff[WIDTH]) rem = diff;
      end
      acc_o   = {{(WIDTH-1){1'b0}}, rem};
      shreg_o = sh;
    end else begin
      pp      = {{BPC{1'b0}}, opnd_i} * {{WIDTH{1'b0}}, shreg_i[WIDTH-1 -: BPC]};
      acc_o   = {acc_i[2*WIDTH-BPC-1:0], {BPC{1'b0}}} + {{(WIDTH-BPC){1'b0}}, pp};
      shreg_o = {shreg_i[WIDTH-BPC-1:0], {BPC{1'b0}}};
    end
  end

endmodule

// File: rtl/apmu_ibex_multdiv_iter.sv
// Iterative RV32M multiply/divide engine with private partial-result registers,
// optional early-out and data-independent timing.
module apmu_ibex_multdiv_iter
  import apmu_ibex_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1,
  parameter bit EARLY_OUT      = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  md_op_e           operator_i,
  input  logic [1:0]       signed_mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             data_ind_timing_i,
  input  logic             kill_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             busy_o
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ITERS - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_iter_state_e     state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  md_op_e             op_q, op_d;
  logic               a_neg_q, a_neg_d, b_neg_q, b_neg_d;
  logic               b_zero_q, b_zero_d, early_q, early_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, shreg_q, shreg_d, result_q, result_d;

  logic               is_div_in, is_div_q, a_neg_in, b_neg_in, ovf_in, early_hit;
  logic [WIDTH-1:0]   a_mag, b_mag, early_res, fix_res, quo, rem;
  logic [2*WIDTH-1:0] prod, step_acc;
  logic [WIDTH-1:0]   step_sh;

  assign is_div_in = (operator_i == MD_OP_DIV) || (operator_i == MD_OP_REM);
  assign is_div_q  = (op_q == MD_OP_DIV) || (op_q == MD_OP_REM);
  assign a_neg_in  = signed_mode_i[0] & op_a_i[WIDTH-1];
  assign b_neg_in  = signed_mode_i[1] & op_b_i[WIDTH-1];
  assign a_mag     = a_neg_in ? -op_a_i : op_a_i;
  assign b_mag     = b_neg_in ? -op_b_i : op_b_i;
  assign ovf_in    = (signed_mode_i == 2'b11) && (op_a_i == MOST_NEG) && (op_b_i == '1);

  always_comb begin
    early_res = '0;
    early_hit = 1'b0;
    if (is_div_in) begin
      if (op_b_i == '0) begin
        early_hit = 1'b1;
        early_res = (operator_i == MD_OP_DIV) ? '1 : op_a_i;
      end else if (ovf_in) begin
        early_hit = 1'b1;
        early_res = (operator_i == MD_OP_DIV) ? op_a_i : '0;
      end
    end else if ((op_a_i == '0) || (op_b_i == '0)) begin
      early_hit = 1'b1;
    end
    early_hit = early_hit & EARLY_OUT & ~data_ind_timing_i;
  end

  apmu_ibex_md_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .div_i   (is_div_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .shreg_i (shreg_q),
    .acc_o   (step_acc),
    .shreg_o (step_sh)
  );

  // A zero divisor keeps the all-ones quotient unsigned regardless of the dividend sign.
  always_comb begin
    prod    = (a_neg_q ^ b_neg_q) ? -acc_q : acc_q;
    quo     = ((a_neg_q ^ b_neg_q) & ~b_zero_q) ? -shreg_q : shreg_q;
    rem     = a_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    fix_res = '0;
    unique case (op_q)
      MD_OP_MULL: fix_res = prod[WIDTH-1:0];
      MD_OP_MULH: fix_res = prod[2*WIDTH-1:WIDTH];
      MD_OP_DIV:  fix_res = quo;
      MD_OP_REM:  fix_res = rem;
      default:    fix_res = '0;
    endcase
  end

  // Input side transfers on in_valid_i & in_ready_o, output side on out_valid_o & out_ready_i;
  // kill_i overrides both and an early-out result still passes through FIX for a uniform 1-cycle delay.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    b_zero_d = b_zero_q;
    early_d  = early_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    shreg_d  = shreg_q;
    result_d = result_q;
    unique case (state_q)
      MD_IDLE: begin
        if (in_valid_i && !kill_i) begin
          op_d     = operator_i;
          a_neg_d  = a_neg_in;
          b_neg_d  = b_neg_in;
          b_zero_d = (op_b_i == '0);
          acc_d    = '0;
          opnd_d   = is_div_in ? b_mag : a_mag;
          shreg_d  = is_div_in ? a_mag : b_mag;
          cnt_d    = CNT_LOAD;
          early_d  = early_hit;
          if (early_hit) begin
            result_d = early_res;
            state_d  = MD_FIX;
          end else begin
            state_d  = MD_CALC;
          end
        end
      end
      MD_CALC: begin
        acc_d   = step_acc;
        shreg_d = step_sh;
        if (cnt_q == '0) state_d = MD_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_FIX: begin
        if (!early_q) result_d = fix_res;
        state_d = MD_DONE;
      end
      MD_DONE: begin
        if (out_ready_i) state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (kill_i && (state_q != MD_IDLE)) state_d = MD_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      op_q     <= MD_OP_MULL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      early_q  <= 1'b0;
      acc_q    <= '0;
      opnd_q   <= '0;
      shreg_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      b_zero_q <= b_zero_d;
      early_q  <= early_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      shreg_q  <= shreg_d;
      result_q <= result_d;
    end
  end

  assign in_ready_o  = (state_q == MD_IDLE);
  assign out_valid_o = (state_q == MD_DONE);
  assign busy_o      = (state_q != MD_IDLE);
  assign result_o    = result_q;

  a_valid_done: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o |-> (state_q == MD_DONE));
  a_ready_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    in_ready_o |-> (state_q == MD_IDLE));
  a_cnt_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q == MD_CALC) && (cnt_q == '0)) |=> (state_q != MD_CALC));
  a_in_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (in_valid_i && !in_ready_o) |=> (in_valid_i && $stable(operator_i) && $stable(signed_mode_i)
                                     && $stable(op_a_i) && $stable(op_b_i)));

endmodule

// File: tb/tb_apmu_ibex_multdiv_iter.sv
// Drives three engine configurations (W32/BPC1, W32/BPC4, W16/BPC1) in lockstep and
// checks results and latency against an arithmetic reference model.
module tb_apmu_ibex_multdiv_iter;
  import apmu_ibex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, kill, out_ready, dit;
  md_op_e      op;
  logic [1:0]  sm;
  logic [31:0] a, b;
  logic [2:0]  rdy, vld, busy;
  logic [31:0] res_a, res_b;
  logic [15:0] res_c;

  int          total = 0;
  int          bad   = 0;
  int          lat[3];
  logic [31:0] got[3];
  logic [31:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  apmu_ibex_multdiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(1), .EARLY_OUT(1'b1)) u_w32 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[0]),
    .operator_i(op), .signed_mode_i(sm), .op_a_i(a), .op_b_i(b),
    .data_ind_timing_i(dit), .kill_i(kill), .out_valid_o(vld[0]),
    .out_ready_i(out_ready), .result_o(res_a), .busy_o(busy[0]));

  apmu_ibex_multdiv_iter #(.WIDTH(32), .BITS_PER_CYCLE(4), .EARLY_OUT(1'b1)) u_w32q (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[1]),
    .operator_i(op), .signed_mode_i(sm), .op_a_i(a), .op_b_i(b),
    .data_ind_timing_i(dit), .kill_i(kill), .out_valid_o(vld[1]),
    .out_ready_i(out_ready), .result_o(res_b), .busy_o(busy[1]));

  apmu_ibex_multdiv_iter #(.WIDTH(16), .BITS_PER_CYCLE(1), .EARLY_OUT(1'b1)) u_w16 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(rdy[2]),
    .operator_i(op), .signed_mode_i(sm), .op_a_i(a[15:0]), .op_b_i(b[15:0]),
    .data_ind_timing_i(dit), .kill_i(kill), .out_valid_o(vld[2]),
    .out_ready_i(out_ready), .result_o(res_c), .busy_o(busy[2]));

  // reference model
  function automatic logic [31:0] ref_res(input md_op_e o, input logic [1:0] s,
                                          input logic [31:0] ai, input logic [31:0] bi,
                                          input int w);
    longint mask, x, y, p;
    mask = (longint'(1) << w) - 1;
    x = 0; x[31:0] = ai; x = x & mask;
    y = 0; y[31:0] = bi; y = y & mask;
    if (s[0] && x[w-1]) x = x - (mask + 1);
    if (s[1] && y[w-1]) y = y - (mask + 1);
    case (o)
      MD_OP_MULL: p = x * y;
      MD_OP_MULH: p = (x * y) >> w;
      MD_OP_DIV:  p = (y == 0) ? mask : x / y;
      default:    p = (y == 0) ? x : x % y;
    endcase
    p = p & mask;
    return p[31:0];
  endfunction

  function automatic int ref_lat(input md_op_e o, input logic [1:0] s,
                                 input logic [31:0] ai, input logic [31:0] bi,
                                 input logic d, input int w, input int bpc);
    longint mask, x, y;
    bit     early;
    mask = (longint'(1) << w) - 1;
    x = 0; x[31:0] = ai; x = x & mask;
    y = 0; y[31:0] = bi; y = y & mask;
    if (o == MD_OP_DIV || o == MD_OP_REM)
      early = (y == 0) || (s == 2'b11 && x == (longint'(1) << (w - 1)) && y == mask);
    else
      early = (x == 0) || (y == 0);
    return (early && !d) ? 1 : (w / bpc + 1);
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input md_op_e o, input logic [1:0] s,
                        input logic [31:0] ai, input logic [31:0] bi, input logic d);
    int          ws[3] = '{32, 32, 16};
    int          bs[3] = '{1, 4, 1};
    logic [31:0] r[3];
    for (int i = 0; i < 3; i++) exp_q.push_back(ref_res(o, s, ai, bi, ws[i]));
    op = o; sm = s; a = ai; b = bi; dit = d; out_ready = 1'b1;
    chk({tag, "_rdy"}, rdy, 3'b111);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = '{-1, -1, -1};
    got = '{32'hx, 32'hx, 32'hx};
    for (int c = 0; c <= 40; c++) begin
      r = '{res_a, res_b, {16'h0, res_c}};
      for (int i = 0; i < 3; i++)
        if (vld[i] && lat[i] < 0) begin
          lat[i] = c;
          got[i] = r[i];
        end
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      step();
    end
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_res%0d", tag, i), got[i], exp_q.pop_front());
      chk($sformatf("%s_lat%0d", tag, i), lat[i], ref_lat(o, s, ai, bi, d, ws[i], bs[i]));
    end
  endtask

  initial begin
    logic        flag;
    md_op_e      ro;
    logic [31:0] ra, rb;

    rst_n = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b1; dit = 1'b0;
    op = MD_OP_MULL; sm = 2'b00; a = '0; b = '0;
    repeat (3) step();
    chk("rst_flags", {rdy, vld, busy}, 9'b111_000_000);
    chk("rst_res", {res_a, res_b, res_c}, 80'h0);
    rst_n = 1'b1;
    step();

    run_op("mulh_ovf", MD_OP_MULH, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("mulh_ovf_const", got[0], 32'h00000000);
    run_op("mull_ovf", MD_OP_MULL, 2'b11, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    chk("mull_ovf_const", got[0], 32'h80000000);
    run_op("div_m7", MD_OP_DIV, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("div_m7_const", got[0], 32'hFFFFFFFD);
    run_op("rem_m7", MD_OP_REM, 2'b11, 32'hFFFFFFF9, 32'd2, 1'b0);
    chk("rem_m7_const", got[0], 32'hFFFFFFFF);
    run_op("divu", MD_OP_DIV, 2'b00, 32'd100, 32'd7, 1'b0);
    chk("divu_const", got[0], 32'd14);
    run_op("remu", MD_OP_REM, 2'b00, 32'd100, 32'd7, 1'b0);
    chk("remu_const", got[0], 32'd2);

    for (int d = 0; d < 2; d++) begin
      run_op($sformatf("div0_d%0d", d), MD_OP_DIV, 2'b11, 32'd5, 32'd0, d[0]);
      chk($sformatf("div0_d%0d_const", d), {got[0], lat[0]}, {32'hFFFFFFFF, (d == 0) ? 32'd1 : 32'd33});
      run_op($sformatf("rem0_d%0d", d), MD_OP_REM, 2'b11, 32'd5, 32'd0, d[0]);
      chk($sformatf("rem0_d%0d_const", d), {got[0], lat[0]}, {32'd5, (d == 0) ? 32'd1 : 32'd33});
      run_op($sformatf("divovf_d%0d", d), MD_OP_DIV, 2'b11, 32'h80000000, 32'hFFFFFFFF, d[0]);
      chk($sformatf("divovf_d%0d_const", d), {got[0], got[1]}, {32'h80000000, 32'h80000000});
      run_op($sformatf("removf_d%0d", d), MD_OP_REM, 2'b11, 32'h80000000, 32'hFFFFFFFF, d[0]);
      chk($sformatf("removf_d%0d_const", d), {got[0], got[1]}, 64'h0);
    end
    chk("bpc4_lat_full", lat[1], 32'd9);

    // kill during CALC, then kill while idle with a pending request
    op = MD_OP_MULL; sm = 2'b00; a = 32'd12345; b = 32'd6789; dit = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    flag = 1'b0;
    repeat (9) begin
      step();
      if (vld[0] | vld[2]) flag = 1'b1;
    end
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_novld_calc", flag, 1'b0);
    chk("kill_rdy", rdy, 3'b111);
    chk("kill_vld", vld, 3'b000);
    in_valid = 1'b1; kill = 1'b1;
    step();
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle_busy", busy, 3'b000);
    run_op("mulhu_ff", MD_OP_MULH, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    chk("mulhu_ff_const", {got[0], got[2]}, {32'hFFFFFFFE, 32'h0000FFFE});

    // async reset mid-CALC
    op = MD_OP_DIV; sm = 2'b00; a = 32'd1000; b = 32'd3; dit = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", {rdy, vld, busy}, 9'b111_000_000);
    chk("arst_res", {res_a, res_b, res_c}, 80'h0);
    step();
    rst_n = 1'b1;
    step();

    // consumer stall in DONE
    op = MD_OP_DIV; sm = 2'b00; a = 32'd1000; b = 32'd7; dit = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 40 && !vld[0]; c++) step();
    repeat (5) begin
      step();
      chk("hold_res", res_a, 32'd142);
      chk("hold_flags", {rdy, vld}, 6'b000_111);
    end
    out_ready = 1'b1;
    step();
    chk("release_flags", {rdy, vld}, 6'b111_000);

    run_op("w16_mull", MD_OP_MULL, 2'b00, 32'h000000FF, 32'h00000101, 1'b0);
    chk("w16_mull_const", got[2], 32'h0000FFFF);

    for (int n = 0; n < 30; n++) begin
      ro = md_op_e'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: ra = 32'h80000000;
        2: ra = 32'hFFFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFFFFFF;
        2: rb = $urandom_range(1, 15);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", n), ro, 2'($urandom_range(0, 3)), ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
